// File: rtl/rc_emu_pkg.sv
// Shared types and constants for the RC step emulator: FSM state encoding,
// default counter width and the all-ones saturation value.
package rc_emu_pkg;

  localparam int unsigned WIDTH_DEF = 24;

  // Truncated to the instance width where used; covers widths up to 64.
  localparam logic [63:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    DISCHARGED  = 2'd0,
    CHARGING    = 2'd1,
    CHARGED     = 2'd2,
    DISCHARGING = 2'd3
  } state_e;

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down level counter clamped to [0, ceiling]; load1 forces the level to 1.
// The next-state value is exported so the controller can act on the edge it lands.
module sat_updown_counter #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load1,
  input  logic [WIDTH-1:0] ceiling,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] level_nxt_c
);

  logic [WIDTH-1:0] level_q;

  always_comb begin
    level_nxt_c = level_q;
    if (load1) begin
      level_nxt_c = WIDTH'(1);
    end else if (inc) begin
      level_nxt_c = (level_q >= ceiling) ? ceiling : level_q + WIDTH'(1);
    end else if (dec) begin
      level_nxt_c = (level_q == '0) ? '0 : level_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_nxt_c;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/rc_step_emulator.sv
// Digital model of the RC network and comparator on the step interface:
// charges a level counter while step_set is high and trips step_input at the threshold.
module rc_step_emulator
  import rc_emu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned HYST  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_set,
  input  logic [WIDTH-1:0] cfg_thresh,
  input  logic [WIDTH-1:0] cfg_full,
  output logic             step_input,
  output logic             discharged,
  output logic [WIDTH-1:0] meas_cycles,
  output logic             meas_valid,
  output logic             abort
);

  localparam logic [WIDTH-1:0] MEAS_MAX = WIDTH'(ALL_ONES);
  localparam logic [WIDTH-1:0] HYST_W   = WIDTH'(HYST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] full_q, full_d;
  logic [WIDTH-1:0] meas_cnt_q, meas_cnt_d;
  logic [WIDTH-1:0] meas_cycles_q, meas_cycles_d;
  logic             step_input_q, step_input_d;
  logic             discharged_q, discharged_d;
  logic             meas_valid_q, meas_valid_d;
  logic             abort_q, abort_d;

  logic [WIDTH-1:0] cfg_thr_c, cfg_full_c, ceiling_c, thr_lo_c, meas_inc_c;
  logic [WIDTH-1:0] level, level_nxt_c;
  logic             latch_c, inc_c, dec_c, load1_c;

  // Clamped config; a charge start uses it directly on the latching edge.
  assign cfg_thr_c  = (cfg_thresh == '0) ? WIDTH'(1) : cfg_thresh;
  assign cfg_full_c = (cfg_full < cfg_thr_c) ? cfg_thr_c : cfg_full;
  assign latch_c    = step_set && ((state_q == DISCHARGED) || (state_q == DISCHARGING));
  assign ceiling_c  = latch_c ? cfg_full_c : full_q;
  assign thr_lo_c   = (thr_q > HYST_W) ? thr_q - HYST_W : '0;
  assign meas_inc_c = (meas_cnt_q == MEAS_MAX) ? MEAS_MAX : meas_cnt_q + WIDTH'(1);

  assign load1_c = step_set && (state_q == DISCHARGED);
  assign inc_c   = step_set && (state_q != DISCHARGED);
  assign dec_c   = !step_set && (state_q != DISCHARGED);

  sat_updown_counter #(
    .WIDTH(WIDTH)
  ) u_level (
    .clk        (clk),
    .reset      (reset),
    .inc        (inc_c),
    .dec        (dec_c),
    .load1      (load1_c),
    .ceiling    (ceiling_c),
    .level      (level),
    .level_nxt_c(level_nxt_c)
  );

  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    full_d        = full_q;
    meas_cnt_d    = meas_cnt_q;
    meas_cycles_d = meas_cycles_q;
    step_input_d  = step_input_q;
    meas_valid_d  = 1'b0;
    abort_d       = 1'b0;

    if (latch_c) begin
      thr_d      = cfg_thr_c;
      full_d     = cfg_full_c;
      meas_cnt_d = WIDTH'(1);
    end

    unique case (state_q)
      DISCHARGED: begin
        if (step_set) begin
          if (level_nxt_c >= cfg_thr_c) begin
            state_d       = CHARGED;
            step_input_d  = 1'b1;
            meas_valid_d  = 1'b1;
            meas_cycles_d = meas_cnt_d;
          end else begin
            state_d = CHARGING;
          end
        end
      end
      CHARGING: begin
        if (step_set) begin
          meas_cnt_d = meas_inc_c;
          if (level_nxt_c >= thr_q) begin
            state_d       = CHARGED;
            step_input_d  = 1'b1;
            meas_valid_d  = 1'b1;
            meas_cycles_d = meas_cnt_d;
          end
        end else begin
          // Falling step_set wins over a same-edge threshold hit.
          abort_d = 1'b1;
          state_d = (level_nxt_c == '0) ? DISCHARGED : DISCHARGING;
        end
      end
      CHARGED: begin
        if (!step_set) begin
          state_d = (level_nxt_c == '0) ? DISCHARGED : DISCHARGING;
          if (level_nxt_c < thr_lo_c) step_input_d = 1'b0;
        end
      end
      DISCHARGING: begin
        if (step_set) begin
          if (level >= cfg_thr_c) begin
            state_d      = CHARGED;
            step_input_d = 1'b1;
          end else if (level_nxt_c >= cfg_thr_c) begin
            state_d       = CHARGED;
            step_input_d  = 1'b1;
            meas_valid_d  = 1'b1;
            meas_cycles_d = meas_cnt_d;
          end else begin
            state_d = CHARGING;
          end
        end else begin
          if (level_nxt_c < thr_lo_c) step_input_d = 1'b0;
          if (level_nxt_c == '0) state_d = DISCHARGED;
        end
      end
      default: state_d = DISCHARGED;
    endcase

    // An empty capacitor never holds the comparator high, whatever the hysteresis.
    if (state_d == DISCHARGED) step_input_d = 1'b0;
    discharged_d = (state_d == DISCHARGED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= DISCHARGED;
      thr_q         <= '0;
      full_q        <= '0;
      meas_cnt_q    <= '0;
      meas_cycles_q <= '0;
      step_input_q  <= 1'b0;
      discharged_q  <= 1'b1;
      meas_valid_q  <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      full_q        <= full_d;
      meas_cnt_q    <= meas_cnt_d;
      meas_cycles_q <= meas_cycles_d;
      step_input_q  <= step_input_d;
      discharged_q  <= discharged_d;
      meas_valid_q  <= meas_valid_d;
      abort_q       <= abort_d;
    end
  end

  assign step_input  = step_input_q;
  assign discharged  = discharged_q;
  assign meas_cycles = meas_cycles_q;
  assign meas_valid  = meas_valid_q;
  assign abort       = abort_q;

endmodule
